// File: rtl/mem_bus_arbiter_if.sv
// Master-side requests and memory-controller side of the arbiter, bundled as one interface.
// The arbiter uses the slave modport; the environment (masters plus memory) uses master.
interface mem_bus_arbiter_if;
  logic [2:0]  reqI;
  logic [35:0] addrCPU;
  logic [35:0] addrUBA;
  logic [35:0] addrCON;
  logic [35:0] dataCPU;
  logic [35:0] dataUBA;
  logic [35:0] dataCON;
  logic [2:0]  ackO;
  logic [2:0]  nxmO;
  logic [35:0] rdataO;
  logic [2:0]  grantO;
  logic        busREQO;
  logic [35:0] busADDRO;
  logic [35:0] busDATAO;
  logic        busACKI;
  logic [35:0] busDATAI;

  modport slave (
    input  reqI, addrCPU, addrUBA, addrCON, dataCPU, dataUBA, dataCON, busACKI, busDATAI,
    output ackO, nxmO, rdataO, grantO, busREQO, busADDRO, busDATAO
  );

  modport master (
    output reqI, addrCPU, addrUBA, addrCON, dataCPU, dataUBA, dataCON, busACKI, busDATAI,
    input  ackO, nxmO, rdataO, grantO, busREQO, busADDRO, busDATAO
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority memory bus arbiter (console > UBA > CPU) with non-existent-memory timeout.
// One bus cycle at a time: IDLE -> WAIT -> DONE (ack pulse) -> TURN -> IDLE.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [35:0] NXM_DATA = 36'o0
) (
  input logic              clkT,
  input logic              rst,
  mem_bus_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StWait, StDone, StTurn} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [35:0] addr_q, addr_d;
  logic [35:0] data_q, data_d;
  logic [35:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        nxm_q, nxm_d;

  always_ff @(posedge clkT) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      nxm_q   <= nxm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    nxm_d   = nxm_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.reqI != 3'b000) begin
          cnt_d   = '0;
          nxm_d   = 1'b0;
          state_d = StWait;
          if (bus_io.reqI[2]) begin
            grant_d = 3'b100;
            addr_d  = bus_io.addrCON;
            data_d  = bus_io.dataCON;
          end else if (bus_io.reqI[1]) begin
            grant_d = 3'b010;
            addr_d  = bus_io.addrUBA;
            data_d  = bus_io.dataUBA;
          end else begin
            grant_d = 3'b001;
            addr_d  = bus_io.addrCPU;
            data_d  = bus_io.dataCPU;
          end
        end
      end
      StWait: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // An ack arriving on the last allowed cycle still beats the timeout.
        if (bus_io.busACKI) begin
          rdata_d = bus_io.busDATAI;
          nxm_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q >= TimeoutLast) begin
          rdata_d = NXM_DATA;
          nxm_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StTurn;
      end
      StTurn: begin
        // Requests are ignored here so a request still held from the done cycle is not re-granted.
        state_d = StIdle;
        grant_d = '0;
        addr_d  = '0;
        data_d  = '0;
        rdata_d = '0;
        cnt_d   = '0;
        nxm_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  logic active;
  assign active = (state_q == StWait) || (state_q == StDone);

  assign bus_io.busREQO  = (state_q == StWait);
  assign bus_io.busADDRO = active ? addr_q : '0;
  assign bus_io.busDATAO = active ? data_q : '0;
  assign bus_io.ackO     = (state_q == StDone) ? grant_q : 3'b000;
  assign bus_io.nxmO     = ((state_q == StDone) && nxm_q) ? grant_q : 3'b000;
  assign bus_io.rdataO   = (state_q == StDone) ? rdata_q : '0;
  assign bus_io.grantO   = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a memory responder predicts each bus cycle from the
// masters' outstanding requests and pushes the expectation; a monitor pops it on every ack.
module tb_mem_bus_arbiter;
  localparam int unsigned TO    = 16;
  localparam logic [35:0] NXM_D = 36'o0;

  logic clkT = 1'b0;
  logic rst  = 1'b1;
  always #5 clkT = ~clkT;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(
    .TIMEOUT  (TO),
    .NXM_DATA (NXM_D)
  ) dut (
    .clkT   (clkT),
    .rst    (rst),
    .bus_io (bus_if.slave)
  );

  logic [2:0]  req_v = 3'b000;
  logic [35:0] addr_v [3] = '{36'o0, 36'o0, 36'o0};
  logic [35:0] data_v [3] = '{36'o0, 36'o0, 36'o0};
  logic        bus_ack_v = 1'b0;
  logic [35:0] bus_rd_v = '0;

  assign bus_if.reqI     = req_v;
  assign bus_if.addrCPU  = addr_v[0];
  assign bus_if.addrUBA  = addr_v[1];
  assign bus_if.addrCON  = addr_v[2];
  assign bus_if.dataCPU  = data_v[0];
  assign bus_if.dataUBA  = data_v[1];
  assign bus_if.dataCON  = data_v[2];
  assign bus_if.busACKI  = bus_ack_v;
  assign bus_if.busDATAI = bus_rd_v;

  typedef struct {
    int          m;
    logic [35:0] addr;
    logic [35:0] data;
    logic [35:0] rdata;
    bit          nxm;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int issued [3] = '{0, 0, 0};
  int acked  [3] = '{0, 0, 0};
  int          force_lat   = -1;
  bit          force_rd_en = 1'b0;
  logic [35:0] force_rd    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [35:0] rand36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [2:0] pending_mask();
    logic [2:0] pm;
    for (int k = 0; k < 3; k++) pm[k] = (issued[k] != acked[k]);
    return pm;
  endfunction

  // Memory responder and reference model: the winner is the highest-priority master that was
  // requesting at the arbitration edge and has not yet been acked.
  initial begin : responder
    bit          in_cyc;
    int          wcnt, lat, m;
    logic [35:0] rd;
    logic [2:0]  req_prev, cand;
    logic [35:0] a_prev [3];
    logic [35:0] d_prev [3];
    exp_t        e;
    in_cyc = 1'b0; wcnt = 0; lat = 0; m = 0; rd = '0; req_prev = '0; cand = '0;
    for (int k = 0; k < 3; k++) begin
      a_prev[k] = '0;
      d_prev[k] = '0;
    end
    forever begin
      @(negedge clkT);
      if (rst || !bus_if.busREQO) begin
        in_cyc    = 1'b0;
        bus_ack_v = 1'b0;
      end else begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          wcnt   = 0;
          cand   = req_prev & pending_mask();
          check("grant_matches_pending_request", 64'(cand != 3'b000), 64'd1);
          m   = cand[2] ? 2 : (cand[1] ? 1 : 0);
          lat = (force_lat >= 0) ? force_lat :
                (($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                              : int'($urandom_range(0, 5)));
          rd  = force_rd_en ? force_rd : rand36();
          if (cand != 3'b000) begin
            e.m      = m;
            e.addr   = a_prev[m];
            e.data   = d_prev[m];
            e.nxm    = (lat >= int'(TO));
            e.rdata  = e.nxm ? NXM_D : rd;
            e.cycles = e.nxm ? int'(TO) : lat + 1;
            exp_q.push_back(e);
          end
        end
        bus_ack_v = (wcnt == lat);
        bus_rd_v  = (wcnt == lat) ? rd : rand36();
        wcnt++;
      end
      req_prev = req_v;
      for (int k = 0; k < 3; k++) begin
        a_prev[k] = addr_v[k];
        d_prev[k] = data_v[k];
      end
    end
  end

  initial begin : monitor
    int   req_cycles;
    bit   prev_ack;
    exp_t e;
    req_cycles = 0;
    prev_ack   = 1'b0;
    forever begin
      @(negedge clkT);
      #1;
      if (rst) begin
        exp_q.delete();
        req_cycles = 0;
        prev_ack   = 1'b0;
      end else begin
        if (bus_if.busREQO) begin
          req_cycles++;
          if (exp_q.size() == 0) check("busREQO_without_grant", 64'd1, 64'd0);
          else begin
            check("busADDRO", 64'(bus_if.busADDRO), 64'(exp_q[0].addr));
            check("busDATAO", 64'(bus_if.busDATAO), 64'(exp_q[0].data));
          end
        end
        if (bus_if.ackO != 3'b000 || bus_if.nxmO != 3'b000) begin
          check("ack_single_cycle", 64'(prev_ack), 64'd0);
          if (exp_q.size() == 0) check("spurious_ack", 64'(bus_if.ackO), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("ackO", 64'(bus_if.ackO), 64'(3'b001 << e.m));
            check("nxmO", 64'(bus_if.nxmO), e.nxm ? 64'(3'b001 << e.m) : 64'd0);
            check("rdataO", 64'(bus_if.rdataO), 64'(e.rdata));
            check("grantO", 64'(bus_if.grantO), 64'(3'b001 << e.m));
            check("busREQO_cycles", 64'(req_cycles), 64'(e.cycles));
            acked[e.m]++;
          end
          req_cycles = 0;
        end
        prev_ack = (bus_if.ackO != 3'b000);
      end
    end
  end

  // One master transaction: raise request, hold until acked, drop in the turnaround cycle.
  task automatic master_txn(input int m, input logic [35:0] a, input logic [35:0] d,
                            input bit scribble);
    int target;
    bit done;
    done   = 1'b0;
    target = acked[m] + 1;
    @(posedge clkT);
    #1;
    addr_v[m] = a;
    data_v[m] = d;
    req_v[m]  = 1'b1;
    issued[m]++;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clkT);
      #1;
      if (scribble && $urandom_range(0, 1) == 1) addr_v[m] = rand36();
      @(negedge clkT);
      #2;
      if (acked[m] >= target) done = 1'b1;
    end
    if (!done) check($sformatf("ack_timeout_master%0d", m), 64'd0, 64'd1);
    @(posedge clkT);
    #1;
    req_v[m] = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  initial begin : main
    repeat (3) @(posedge clkT);
    @(negedge clkT);
    check("reset_busREQO", 64'(bus_if.busREQO), 64'd0);
    check("reset_ackO", 64'(bus_if.ackO), 64'd0);
    check("reset_nxmO", 64'(bus_if.nxmO), 64'd0);
    check("reset_grantO", 64'(bus_if.grantO), 64'd0);
    check("reset_rdataO", 64'(bus_if.rdataO), 64'd0);
    check("reset_busADDRO", 64'(bus_if.busADDRO), 64'd0);
    @(posedge clkT);
    #1 rst = 1'b0;

    // Single CPU read, ack on the third wait cycle; address scribbled while waiting.
    force_lat   = 2;
    force_rd_en = 1'b1;
    force_rd    = 36'o123456_654321;
    master_txn(0, 36'o000000_001000, 36'o0, 1'b1);
    force_rd_en = 1'b0;
    force_lat   = -1;

    // All three at once: console, UBA, CPU.
    fork
      master_txn(0, 36'o000000_000100, rand36(), 1'b0);
      master_txn(1, 36'o000000_000200, rand36(), 1'b0);
      master_txn(2, 36'o000000_000300, rand36(), 1'b0);
    join

    // UBA to non-existent memory, then a normal UBA cycle.
    force_lat = 100;
    master_txn(1, 36'o000777_000000, rand36(), 1'b0);
    force_lat = 1;
    master_txn(1, 36'o000000_004000, rand36(), 1'b0);

    // Ack on the same cycle the timeout would fire.
    force_lat = int'(TO) - 1;
    master_txn(2, 36'o000000_002000, rand36(), 1'b0);

    // Reset in the middle of a UBA write.
    force_lat = 200;
    @(posedge clkT);
    #1;
    addr_v[1] = 36'o000000_006000;
    data_v[1] = rand36();
    req_v[1]  = 1'b1;
    issued[1]++;
    repeat (6) @(posedge clkT);
    #1 rst = 1'b1;
    @(posedge clkT);
    #1;
    rst      = 1'b0;
    req_v[1] = 1'b0;
    issued[1]--;
    force_lat = -1;
    repeat (4) begin
      @(negedge clkT);
      #1;
      check("after_reset_busREQO", 64'(bus_if.busREQO), 64'd0);
      check("after_reset_ackO", 64'(bus_if.ackO), 64'd0);
      check("after_reset_nxmO", 64'(bus_if.nxmO), 64'd0);
      check("after_reset_grantO", 64'(bus_if.grantO), 64'd0);
    end
    master_txn(0, 36'o000000_010000, rand36(), 1'b0);

    // Random traffic from all three masters.
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 6)) @(posedge clkT);
        master_txn(0, rand36(), rand36(), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 6)) @(posedge clkT);
        master_txn(1, rand36(), rand36(), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 30)) @(posedge clkT);
        master_txn(2, rand36(), rand36(), 1'($urandom_range(0, 1)));
      end
    join

    repeat (10) @(posedge clkT);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
